// File: rtl/data_mem_responder.sv
// Memory-side responder: word-organised data RAM behind a single-outstanding
// load/store handshake with a fixed, parameterised response latency.
module data_mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        request,
    input  logic        we_re,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  mask,
    output logic        ready,
    output logic        data_valid,
    output logic [31:0] rdata,
    output logic        err
);
    localparam int         DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_mask;
    logic [31:0] r_mem [DEPTH];

    logic                  w_accept;
    logic                  w_fire;
    logic                  w_err;
    logic                  w_op_we;
    logic [31:0]           w_op_addr;
    logic [31:0]           w_op_wdata;
    logic [3:0]            w_op_mask;
    logic [31:0]           w_lane;
    logic [ADDR_WIDTH-1:0] w_idx;

    assign w_accept = request && ready;

    // With single-cycle latency the access completes on the accept edge itself,
    // so it works from the live inputs instead of the latched request.
    always_comb begin
        if (LATENCY == 1) begin
            w_op_we    = we_re;
            w_op_addr  = addr;
            w_op_wdata = wdata;
            w_op_mask  = mask;
            w_fire     = w_accept && !rst;
        end else begin
            w_op_we    = r_we;
            w_op_addr  = r_addr;
            w_op_wdata = r_wdata;
            w_op_mask  = r_mask;
            w_fire     = !rst && (r_state == WAIT) && (r_cnt == 4'd1);
        end
    end

    assign w_idx = w_op_addr[ADDR_WIDTH+1:2];
    assign w_err = ((w_op_addr >> (ADDR_WIDTH + 2)) != 32'd0) || (w_op_mask == 4'b0000);

    always_comb begin
        w_lane = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            w_lane[8*i +: 8] = {8{w_op_mask[i]}};
        end
    end

    // Byte-enabled write on the edge that enters the response cycle.
    always_ff @(posedge clk) begin
        if (w_fire && w_op_we && !w_err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_op_mask[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_op_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            ready      <= 1'b1;
            data_valid <= 1'b0;
            rdata      <= '0;
            err        <= 1'b0;
        end else begin
            data_valid <= w_fire;
            err        <= w_fire && w_err;
            rdata      <= (w_fire && !w_op_we && !w_err) ? (r_mem[w_idx] & w_lane) : '0;

            if (w_accept) begin
                r_we    <= we_re;
                r_addr  <= addr;
                r_wdata <= wdata;
                r_mask  <= mask;
            end

            case (r_state)
                IDLE, RESP: begin
                    if (w_accept) begin
                        r_cnt   <= CNT_LOAD;
                        r_state <= (LATENCY == 1) ? RESP : WAIT;
                        ready   <= (LATENCY == 1);
                    end else begin
                        r_state <= IDLE;
                        ready   <= 1'b1;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= RESP;
                        ready   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    ready   <= 1'b1;
                end
            endcase
        end
    end
endmodule
